pu_spi: RTL and testbench
=========================

PU_SPI -- requirements
Module: pu_spi

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the data bus and of one SPI word.
REQ-002 Parameter ATTR_WIDTH, default 4: width of the attribute bus.
REQ-003 Parameter BUFFER_SIZE, default 3: depth in words of each internal buffer.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 signal_wr  input  1  write strobe; data_in is accepted each clk it is high.
REQ-007 data_in  input  DATA_WIDTH  word from the NITTA data bus.
REQ-008 attr_in  input  ATTR_WIDTH  attributes from the NITTA bus; ignored.
REQ-009 signal_oe  input  1  read strobe; one word is read each clk it is high.
REQ-010 data_out  output  DATA_WIDTH  word to the NITTA data bus.
REQ-011 attr_out  output  ATTR_WIDTH  attributes; bit 0 is INVALID.
REQ-012 flag_cycle  input  1  one-clk pulse marking a new computational cycle.
REQ-013 flag_start  output  1  one-clk pulse when an SPI transaction starts.
REQ-014 flag_stop  output  1  one-clk pulse when an SPI transaction ends.
REQ-015 mosi  input  1  SPI master-out data.
REQ-016 miso  output  1  SPI slave-out data.
REQ-017 sclk  input  1  SPI clock, driven by the external master.
REQ-018 cs  input  1  SPI chip select, active-low.

Function
REQ-019 The block SHALL be an SPI slave (CPOL=0, CPHA=0) that exchanges DATA_WIDTH-bit words with the master, MSB first, in consecutive groups of DATA_WIDTH sclk periods.
REQ-020 The block SHALL hold four buffers of BUFFER_SIZE words: NITTA-send (NS), SPI-transmit (ST), SPI-receive (SR) and NITTA-receive (NR).
REQ-021 Synchronisation: sclk, cs and mosi SHALL pass through 2-FF synchronisers; edges are detected on the synchronised signals; correct operation requires f_sclk <= f_clk/4.
REQ-022 Write: each clk with signal_wr=1 SHALL store data_in into NS[wr_ptr] and increment wr_ptr; writes with wr_ptr=BUFFER_SIZE are ignored.
REQ-023 Read: while signal_oe=1, data_out SHALL combinationally equal NR[rd_ptr] with attr_out=0; rd_ptr increments at each such clk edge.
REQ-024 A read with rd_ptr >= the number of valid NR words SHALL give data_out=0 and attr_out[0]=1, and rd_ptr SHALL not increment.
REQ-025 While signal_oe=0, data_out and attr_out SHALL be 0, so the outputs can be OR-ed onto a shared bus.
REQ-026 At each cs falling edge, flag_start SHALL pulse for one clk, the bit counter SHALL clear, the SR and ST pointers SHALL clear, and ST[0] SHALL load into the shift register.
REQ-027 SPI receive: mosi SHALL be sampled on each synchronised sclk rising edge.
REQ-028 SPI word completion: after DATA_WIDTH sampled bits, the word SHALL be stored into SR[sr_ptr] (dropped once sr_ptr=BUFFER_SIZE), sr_ptr SHALL increment, and the next ST word SHALL load.
REQ-029 SPI transmit: miso SHALL shift on each synchronised sclk falling edge; ST words beyond the NS count from the previous cycle SHALL transmit as 0.
REQ-030 While cs=1, miso SHALL be 0; the cs rising edge SHALL pulse flag_stop for one clk and SHALL discard any partial word.
REQ-031 On flag_cycle=1, in one clk the block SHALL copy NS to ST (with its count) and SR to NR (with its count), then clear NS, SR, wr_ptr, rd_ptr and sr_ptr.
REQ-032 flag_cycle and signal_wr in the same clk: the swap SHALL happen first and data_in SHALL land in NS[0] with wr_ptr=1.
REQ-033 flag_cycle and signal_oe in the same clk: data_out SHALL show the pre-swap NR word.
REQ-034 flag_cycle while cs=0: the in-progress word SHALL complete into the cleared SR.

Reset
REQ-035 While rst=1, all buffers, pointers, counts, the shift register and the synchronisers SHALL clear to 0.
REQ-036 While rst=1, data_out, attr_out, miso, flag_start and flag_stop SHALL be 0; operation resumes on the first clk after deassertion.

Configuration
REQ-037 With macro PU_SPI_LSB_FIRST_EN defined, SPI words SHALL be shifted in and out LSB first.
REQ-038 Without PU_SPI_LSB_FIRST_EN, SPI words SHALL be shifted MSB first; all other behaviour is identical in both builds.

Verification
REQ-039 Reset: rst=1 mid-transfer -> all outputs 0 and rd_ptr=wr_ptr=0 on the next clk.
REQ-040 Write then cycle: signal_wr with 0x01, then 0x02, then flag_cycle pulse, then cs low and 16 sclk -> miso carries 0x01 then 0x02, flag_start then flag_stop each pulse once.
REQ-041 SPI receive: master sends 0xA5, 0x3C, then flag_cycle; signal_oe held 3 clks -> data_out 0xA5, 0x3C, then 0 with attr_out[0]=1.
REQ-042 Overflow: 4 writes (1,2,3,4) with BUFFER_SIZE=3, then flag_cycle and 32 sclk -> miso carries 1,2,3,0.
REQ-043 Simultaneity: signal_wr=0x07 in the same clk as flag_cycle -> 0x07 is the first word transmitted after the next flag_cycle.
REQ-044 Idle read: signal_oe with no data received -> data_out=0, attr_out=0001.

Source files
------------

// File: rtl/pu_spi.sv
// SPI slave processing unit (CPOL=0, CPHA=0) bridging the NITTA data bus and an
// external SPI master through four word buffers:
//   NS: written by the NITTA bus,  ST: transmitted on miso,
//   SR: received from mosi,        NR: read by the NITTA bus.
// flag_cycle swaps NS->ST and SR->NR and clears the writable side.
// Ports:
//   clk, rst                  system clock, asynchronous active-high reset
//   signal_wr, data_in        NITTA write strobe and word
//   attr_in                   NITTA attributes (ignored)
//   signal_oe                 NITTA read strobe
//   data_out, attr_out        NITTA read word / attributes (bit 0 = INVALID),
//                             zero while signal_oe=0 so they can be OR-ed
//   flag_cycle                computational cycle pulse (buffer swap)
//   flag_start, flag_stop     one-clk pulses at SPI transaction start/end
//   mosi, miso, sclk, cs      SPI slave pins (cs active-low)
// Build option: define PU_SPI_LSB_FIRST_EN to shift SPI words LSB first.
module pu_spi #(
    parameter int DATA_WIDTH  = 8,
    parameter int ATTR_WIDTH  = 4,
    parameter int BUFFER_SIZE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    input  logic                  flag_cycle,
    output logic                  flag_start,
    output logic                  flag_stop,
    input  logic                  mosi,
    output logic                  miso,
    input  logic                  sclk,
    input  logic                  cs
);
    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE + 1);
    localparam int unsigned IDX_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PTR_W-1:0] BUF_FULL = PTR_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] ns_buf [BUFFER_SIZE];
    logic [DATA_WIDTH-1:0] st_buf [BUFFER_SIZE];
    logic [DATA_WIDTH-1:0] sr_buf [BUFFER_SIZE];
    logic [DATA_WIDTH-1:0] nr_buf [BUFFER_SIZE];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, sr_ptr, st_ptr, st_cnt, nr_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [DATA_WIDTH-1:0] rx_sh, tx_sh;
    logic sclk_meta, sclk_sync, sclk_prev;
    logic cs_meta, cs_sync, cs_prev;
    logic mosi_meta, mosi_sync;
    logic active;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, word_done, rd_valid, tx_bit;
    logic [DATA_WIDTH-1:0] rx_next, tx_shifted, st_first_word, st_next_word;
    logic [PTR_W-1:0] st_ptr_inc;
    logic unused_attr;

    assign unused_attr = ^attr_in;

    // Edge detection on synchronised pins; sclk only counts inside a started transaction
    always_comb begin
        sclk_rise = active & ~cs_sync & sclk_sync & ~sclk_prev;
        sclk_fall = active & ~cs_sync & ~sclk_sync & sclk_prev;
        cs_fall   = ~cs_sync & cs_prev;
        cs_rise   = active & cs_sync & ~cs_prev;
        word_done = sclk_rise & (bit_cnt == BIT_LAST);
    end

    // Bit ordering of the shift registers
    always_comb begin
`ifdef PU_SPI_LSB_FIRST_EN
        rx_next    = {mosi_sync, rx_sh[DATA_WIDTH-1:1]};
        tx_shifted = {1'b0, tx_sh[DATA_WIDTH-1:1]};
        tx_bit     = tx_sh[0];
`else
        rx_next    = {rx_sh[DATA_WIDTH-2:0], mosi_sync};
        tx_shifted = {tx_sh[DATA_WIDTH-2:0], 1'b0};
        tx_bit     = tx_sh[DATA_WIDTH-1];
`endif
    end

    // ST words past the count handed over at the last swap transmit as zero
    always_comb begin
        st_ptr_inc    = (st_ptr == BUF_FULL) ? st_ptr : st_ptr + PTR_W'(1);
        st_first_word = (st_cnt != '0) ? st_buf[0] : '0;
        st_next_word  = (st_ptr_inc < st_cnt) ? st_buf[IDX_W'(st_ptr_inc)] : '0;
    end

    // NITTA read port is combinational so it can be OR-ed onto the shared bus
    always_comb begin
        rd_valid = rd_ptr < nr_cnt;
        data_out = '0;
        attr_out = '0;
        if (!rst && signal_oe) begin
            if (rd_valid) data_out = nr_buf[IDX_W'(rd_ptr)];
            else          attr_out = ATTR_WIDTH'(1'b1);
        end
    end

    assign miso = active & tx_bit;

    // Synchronisers, SPI engine, NITTA pointers and the cycle swap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                ns_buf[i] <= '0;
                st_buf[i] <= '0;
                sr_buf[i] <= '0;
                nr_buf[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sr_ptr     <= '0;
            st_ptr     <= '0;
            st_cnt     <= '0;
            nr_cnt     <= '0;
            bit_cnt    <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            sclk_meta  <= 1'b0;
            sclk_sync  <= 1'b0;
            sclk_prev  <= 1'b0;
            cs_meta    <= 1'b0;
            cs_sync    <= 1'b0;
            cs_prev    <= 1'b0;
            mosi_meta  <= 1'b0;
            mosi_sync  <= 1'b0;
            active     <= 1'b0;
            flag_start <= 1'b0;
            flag_stop  <= 1'b0;
        end else begin
            sclk_meta  <= sclk;
            sclk_sync  <= sclk_meta;
            sclk_prev  <= sclk_sync;
            cs_meta    <= cs;
            cs_sync    <= cs_meta;
            cs_prev    <= cs_sync;
            mosi_meta  <= mosi;
            mosi_sync  <= mosi_meta;
            flag_start <= cs_fall;
            flag_stop  <= cs_rise;

            if (sclk_rise) begin
                rx_sh   <= rx_next;
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end
            // The fall right after a word boundary must not shift the freshly loaded word
            if (sclk_fall && bit_cnt != '0) tx_sh <= tx_shifted;
            if (word_done) begin
                st_ptr <= st_ptr_inc;
                tx_sh  <= st_next_word;
                if (sr_ptr != BUF_FULL) begin
                    sr_buf[IDX_W'(sr_ptr)] <= rx_next;
                    sr_ptr <= sr_ptr + PTR_W'(1);
                end
            end

            if (signal_wr && wr_ptr != BUF_FULL) begin
                ns_buf[IDX_W'(wr_ptr)] <= data_in;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (signal_oe && rd_valid) rd_ptr <= rd_ptr + PTR_W'(1);

            // Swap first; a same-clk write or completed word lands in the cleared buffer
            if (flag_cycle) begin
                for (int i = 0; i < BUFFER_SIZE; i++) begin
                    st_buf[i] <= ns_buf[i];
                    nr_buf[i] <= sr_buf[i];
                    ns_buf[i] <= '0;
                    sr_buf[i] <= '0;
                end
                st_cnt <= wr_ptr;
                nr_cnt <= sr_ptr;
                rd_ptr <= '0;
                wr_ptr <= signal_wr ? PTR_W'(1) : '0;
                if (signal_wr) ns_buf[0] <= data_in;
                sr_ptr <= word_done ? PTR_W'(1) : '0;
                if (word_done) sr_buf[0] <= rx_next;
            end

            if (cs_rise) begin
                active  <= 1'b0;
                bit_cnt <= '0;
            end
            if (cs_fall) begin
                active  <= 1'b1;
                bit_cnt <= '0;
                sr_ptr  <= '0;
                st_ptr  <= '0;
                tx_sh   <= st_first_word;
            end
        end
    end
endmodule

// File: tb/tb_pu_spi.sv
// Directed self-checking bench for pu_spi: NITTA bus transfers, buffer swap,
// SPI master exchanges (sclk = clk/12) and reset behaviour.
module tb_pu_spi;
    logic       clk = 1'b0;
    logic       rst;
    logic       signal_wr;
    logic [7:0] data_in;
    logic [3:0] attr_in;
    logic       signal_oe;
    logic [7:0] data_out;
    logic [3:0] attr_out;
    logic       flag_cycle;
    logic       flag_start;
    logic       flag_stop;
    logic       mosi;
    logic       miso;
    logic       sclk;
    logic       cs;

    int vec  = 0;
    int miss = 0;
    int n_start = 0;
    int n_stop  = 0;

    pu_spi #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .BUFFER_SIZE(3)) dut (
        .clk(clk), .rst(rst),
        .signal_wr(signal_wr), .data_in(data_in), .attr_in(attr_in),
        .signal_oe(signal_oe), .data_out(data_out), .attr_out(attr_out),
        .flag_cycle(flag_cycle), .flag_start(flag_start), .flag_stop(flag_stop),
        .mosi(mosi), .miso(miso), .sclk(sclk), .cs(cs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (flag_start) n_start++;
        if (flag_stop)  n_stop++;
    end

    // One NITTA-side clock of stimulus, applied at the falling edge
    task automatic nitta(input logic wr, input logic [7:0] d, input logic oe, input logic cyc);
        @(negedge clk);
        signal_wr  = wr;
        data_in    = d;
        signal_oe  = oe;
        flag_cycle = cyc;
    endtask

    task automatic cycle_pulse();
        nitta(1'b0, 8'h00, 1'b0, 1'b1);
        nitta(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic spi_begin();
        cs = 1'b0;
        #60;
    endtask

    task automatic spi_end();
        #60;
        cs = 1'b1;
        #60;
    endtask

    // One master word: mosi driven after sclk falls, miso sampled just before sclk rises
    task automatic spi_word(input logic [7:0] m, output logic [7:0] s);
        s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int b;
`ifdef PU_SPI_LSB_FIRST_EN
            b = i;
`else
            b = 7 - i;
`endif
            mosi = m[b];
            #60;
            s[b] = miso;
            sclk = 1'b1;
            #60;
            sclk = 1'b0;
        end
    endtask

    task automatic check_read(input string name, input logic [7:0] exp_d, input logic [3:0] exp_a);
        #1;
        vec++;
        if (data_out !== exp_d || attr_out !== exp_a) begin
            miss++;
            $display("FAIL %s: data_out=%h attr_out=%b, expected %h %b", name, data_out, attr_out, exp_d, exp_a);
        end
    endtask

    task automatic check_word(input string name, input logic [7:0] got, input logic [7:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; signal_wr = 1'b0; data_in = 8'h00; attr_in = 4'h0;
        signal_oe = 1'b1; flag_cycle = 1'b0; mosi = 1'b0; sclk = 1'b0; cs = 1'b1;
        #22;
        check_read("reset_bus", 8'h00, 4'h0);
        vec++;
        if ({miso, flag_start, flag_stop} !== 3'b000) begin
            miss++;
            $display("FAIL reset_pins: miso/start/stop=%b, expected 000", {miso, flag_start, flag_stop});
        end
        nitta(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        vec++;
        if ({miso, n_start, n_stop} !== {1'b0, 32'd0, 32'd0}) begin
            miss++;
            $display("FAIL post_reset_idle: miso=%b starts=%0d stops=%0d, expected 0 0 0", miso, n_start, n_stop);
        end
    endtask

    task automatic test_idle_read();
        nitta(1'b0, 8'h00, 1'b1, 1'b0);
        check_read("idle_read", 8'h00, 4'b0001);
        nitta(1'b0, 8'h00, 1'b0, 1'b0);
        check_read("idle_no_oe", 8'h00, 4'b0000);
    endtask

    task automatic test_write_cycle_receive();
        logic [7:0] s;
        int s0, p0;
        nitta(1'b1, 8'h01, 1'b0, 1'b0);
        nitta(1'b1, 8'h02, 1'b0, 1'b0);
        cycle_pulse();
        s0 = n_start; p0 = n_stop;
        spi_begin();
        spi_word(8'hA5, s);
        check_word("tx_word0", s, 8'h01);
        spi_word(8'h3C, s);
        check_word("tx_word1", s, 8'h02);
        spi_end();
        check_word("start_pulses", 8'(n_start - s0), 8'd1);
        check_word("stop_pulses", 8'(n_stop - p0), 8'd1);
        vec++;
        if (miso !== 1'b0) begin
            miss++;
            $display("FAIL miso_cs_high: miso=%b, expected 0", miso);
        end
        cycle_pulse();
        nitta(1'b0, 8'h00, 1'b1, 1'b0);
        check_read("rx_read0", 8'hA5, 4'h0);
        @(negedge clk);
        check_read("rx_read1", 8'h3C, 4'h0);
        @(negedge clk);
        check_read("rx_read_past_end", 8'h00, 4'b0001);
        @(negedge clk);
        check_read("rx_read_hold", 8'h00, 4'b0001);
        nitta(1'b0, 8'h00, 1'b0, 1'b0);
        check_read("rx_oe_low", 8'h00, 4'h0);
    endtask

    task automatic test_overflow();
        logic [7:0] s;
        logic [7:0] exp_tx [4] = '{8'h01, 8'h02, 8'h03, 8'h00};
        logic [7:0] send   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] exp_rd [4] = '{8'h11, 8'h22, 8'h33, 8'h00};
        for (int i = 1; i <= 4; i++) nitta(1'b1, 8'(i), 1'b0, 1'b0);
        cycle_pulse();
        spi_begin();
        for (int i = 0; i < 4; i++) begin
            spi_word(send[i], s);
            check_word($sformatf("ovf_tx%0d", i), s, exp_tx[i]);
        end
        spi_end();
        cycle_pulse();
        for (int i = 0; i < 4; i++) begin
            nitta(1'b0, 8'h00, 1'b1, 1'b0);
            check_read($sformatf("ovf_rd%0d", i), exp_rd[i], (i == 3) ? 4'b0001 : 4'b0000);
        end
        nitta(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        logic [7:0] s;
        spi_begin();
        spi_word(8'h5A, s);
        check_word("empty_st_zero", s, 8'h00);
        spi_end();
        cycle_pulse();
        nitta(1'b1, 8'h07, 1'b1, 1'b1);
        check_read("oe_with_cycle", 8'h5A, 4'h0);
        nitta(1'b0, 8'h00, 1'b0, 1'b0);
        cycle_pulse();
        spi_begin();
        spi_word(8'h00, s);
        check_word("wr_with_cycle", s, 8'h07);
        spi_word(8'h00, s);
        check_word("wr_with_cycle_only1", s, 8'h00);
        spi_end();
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] s;
        nitta(1'b1, 8'h99, 1'b0, 1'b0);
        nitta(1'b0, 8'h00, 1'b0, 1'b0);
        cycle_pulse();
        spi_begin();
        mosi = 1'b1;
        repeat (3) begin
            #60 sclk = 1'b1;
            #60 sclk = 1'b0;
        end
        @(negedge clk);
        signal_oe = 1'b1;
        rst = 1'b1;
        check_read("rst_mid_bus", 8'h00, 4'h0);
        vec++;
        if ({miso, flag_start, flag_stop} !== 3'b000) begin
            miss++;
            $display("FAIL rst_mid_pins: miso/start/stop=%b, expected 000", {miso, flag_start, flag_stop});
        end
        cs = 1'b1; mosi = 1'b0; signal_oe = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        nitta(1'b0, 8'h00, 1'b1, 1'b0);
        check_read("rst_rd_ptr", 8'h00, 4'b0001);
        nitta(1'b1, 8'h66, 1'b0, 1'b0);
        nitta(1'b0, 8'h00, 1'b0, 1'b0);
        cycle_pulse();
        spi_begin();
        spi_word(8'h00, s);
        check_word("rst_wr_ptr", s, 8'h66);
        spi_end();
    endtask

    initial begin
        test_reset();
        test_idle_read();
        test_write_cycle_receive();
        test_overflow();
        test_simultaneous();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
